multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL have these ports:
- clk  input  1  single clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-high reset
- op  input  2  instruction op field: 00 data-proc, 01 memory, 10 branch, 11 undefined
- funct  input  6  [5]=I (immediate), [4:1]=cmd, [0]=S (data-proc) or L (memory)
- rd  input  4  destination register index
- cond  input  4  condition field
- alu_flag  input  4  {N,Z,C,V} from the ALU
- pc_write  output  1  PC load enable
- adr_src  output  1  memory address select: 0 PC, 1 ALU result
- mem_write  output  1  data memory write enable
- ir_write  output  1  instruction register load
- reg_write  output  1  register file write enable
- result_src  output  2  result select: 00 ALU-out register, 01 read data, 10 ALU direct
- alu_src_a  output  1  ALU operand A: 0 register A, 1 PC
- alu_src_b  output  2  ALU operand B: 00 register, 01 extended immediate, 10 constant 4
- alu_control  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- imm_src  output  2  equals op (combinational)
- reg_src  output  2  [0]=(op==10), [1]=(op==01) (combinational)
- flags  output  4  architectural {N,Z,C,V} register

Function
REQ-003 The FSM SHALL use 4-bit states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9; codes 10-15 SHALL go to FETCH.
REQ-004 Transitions SHALL be:
- FETCH->DECODE
- DECODE->MEMADR if op=01; EXECI if op=00 and I=1; EXECR if op=00 and I=0; BRANCH if op=10; FETCH if op=11
- MEMADR->MEMRD if L=1, else MEMWR
- MEMRD->MEMWB
- EXECR/EXECI->ALUWB
- MEMWB, MEMWR, ALUWB and BRANCH->FETCH
REQ-005 All control outputs SHALL default to 0 and are asserted only as listed per state:
- FETCH: ir_write=1, pc_write=1, alu_src_a=1, alu_src_b=10, result_src=10
- DECODE: alu_src_a=1, alu_src_b=10, result_src=10
- MEMADR: alu_src_b=01
- MEMRD: adr_src=1
- MEMWB: result_src=01, reg_write=cond_ex
- MEMWR: adr_src=1, mem_write=cond_ex
- EXECR: alu_src_b=00, alu_control=decoded
- EXECI: alu_src_b=01, alu_control=decoded
- ALUWB: reg_write=cond_ex & ~no_write, pc_write=cond_ex & (rd==15)
- BRANCH: alu_src_b=01, result_src=10, pc_write=cond_ex
REQ-006 Command decode SHALL map cmd 0100->ADD, 0010->SUB, 0000->AND, 1100->ORR, 1010->SUB with no_write=1 (CMP); any other cmd SHALL give ADD with no_write=1.
REQ-007 cond_ex SHALL be evaluated from the flags register: 0000 EQ, 0001 NE, 0010 CS, 0011 CC, 0100 MI, 0101 PL, 0110 VS, 0111 VC, 1000 HI, 1001 LS, 1010 GE, 1011 LT, 1100 GT, 1101 LE, 1110 AL; cond=1111 SHALL give cond_ex=0.
REQ-008 In EXECR and EXECI, when S=1 and cond_ex=1, flags[3:2] SHALL load alu_flag[3:2] at the clock edge, and flags[1:0] SHALL load alu_flag[1:0] only for ADD/SUB/CMP; no other state writes flags.
REQ-009 A suppressed instruction (cond_ex=0) SHALL still traverse its full state sequence, with no write strobe.

Reset
REQ-010 Reset SHALL force state=FETCH and flags=0000 immediately (asynchronously), including mid-instruction; no write strobe SHALL be asserted while reset is high.

Configuration
REQ-011 With MCTRL_WAIT_EN defined, the block SHALL add input mem_ready (1 bit) and SHALL hold in FETCH, MEMRD and MEMWR while mem_ready=0, with all strobes (ir_write, pc_write, mem_write) gated off until the ready cycle.
REQ-012 Without MCTRL_WAIT_EN, the mem_ready port SHALL be absent and each state SHALL last exactly one cycle.

Verification
REQ-013 Reset asserted mid-MEMRD: state=FETCH and flags=0 without a clock edge; ir_write=1 on the first cycle after release.
REQ-014 ADD register (op=00, funct=001000, cond=1110): FETCH, DECODE, EXECR, ALUWB; reg_write=1 in cycle 4; total 4 cycles.
REQ-015 CMP immediate with S=1 and alu_flag=0100, then BNE (cond=0001): flags=0100, the branch takes 3 cycles and pc_write=0 in BRANCH.
REQ-016 LDR (op=01, L=1): 5 cycles, reg_write=1 in MEMWB only. STR with cond=0000 and Z=0: mem_write never asserted.
REQ-017 ALU op with rd=15, cond=AL: pc_write=1 in both FETCH and ALUWB.
REQ-018 MCTRL_WAIT_EN build with mem_ready low for 3 cycles in FETCH: state holds, ir_write=0, then one ir_write pulse when ready rises.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control unit: FSM, ALU command decode, condition check, flags register.
// Optional `MCTRL_WAIT_EN adds mem_ready and stalls FETCH/MEMRD/MEMWR until memory is ready.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
`ifdef MCTRL_WAIT_EN
  input  logic       mem_ready,
`endif
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flag,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_control,
  output logic [1:0] imm_src,
  output logic [1:0] reg_src,
  output logic [3:0] flags
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t     r_state, w_next;
  logic [3:0] r_flags;
  logic       w_ready, w_cond_ex, w_no_write;
  logic [1:0] w_alu_op;
  logic       w_pcw, w_mw, w_irw, w_rw;
  logic       w_n, w_z, w_c, w_v;

`ifdef MCTRL_WAIT_EN
  assign w_ready = mem_ready;
`else
  assign w_ready = 1'b1;
`endif

  assign {w_n, w_z, w_c, w_v} = r_flags;
  assign flags   = r_flags;
  assign imm_src = op;
  assign reg_src = {op == 2'b01, op == 2'b10};

  always_comb begin
    case (cond)
      4'b0000: w_cond_ex = w_z;
      4'b0001: w_cond_ex = ~w_z;
      4'b0010: w_cond_ex = w_c;
      4'b0011: w_cond_ex = ~w_c;
      4'b0100: w_cond_ex = w_n;
      4'b0101: w_cond_ex = ~w_n;
      4'b0110: w_cond_ex = w_v;
      4'b0111: w_cond_ex = ~w_v;
      4'b1000: w_cond_ex = w_c & ~w_z;
      4'b1001: w_cond_ex = ~w_c | w_z;
      4'b1010: w_cond_ex = (w_n == w_v);
      4'b1011: w_cond_ex = (w_n != w_v);
      4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
      4'b1101: w_cond_ex = w_z | (w_n != w_v);
      4'b1110: w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    w_alu_op   = 2'b00;
    w_no_write = 1'b0;
    case (funct[4:1])
      4'b0100: w_alu_op = 2'b00;
      4'b0010: w_alu_op = 2'b01;
      4'b0000: w_alu_op = 2'b10;
      4'b1100: w_alu_op = 2'b11;
      4'b1010: begin w_alu_op = 2'b01; w_no_write = 1'b1; end
      default: begin w_alu_op = 2'b00; w_no_write = 1'b1; end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // C/V are only meaningful for the arithmetic commands (ADD/SUB/CMP, alu_op[1]==0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= '0;
    end else if ((r_state == S_EXECR || r_state == S_EXECI) && funct[0] && w_cond_ex) begin
      r_flags[3:2] <= alu_flag[3:2];
      if (!w_alu_op[1]) r_flags[1:0] <= alu_flag[1:0];
    end
  end

  always_comb begin
    w_next      = S_FETCH;
    w_pcw       = 1'b0;
    w_mw        = 1'b0;
    w_irw       = 1'b0;
    w_rw        = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_irw = w_ready; w_pcw = w_ready;
        alu_src_a = 1'b1; alu_src_b = 2'b10; result_src = 2'b10;
        w_next = w_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = 1'b1; alu_src_b = 2'b10; result_src = 2'b10;
        case (op)
          2'b01:   w_next = S_MEMADR;
          2'b00:   w_next = funct[5] ? S_EXECI : S_EXECR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_b = 2'b01;
        w_next = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adr_src = 1'b1;
        w_next = w_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        result_src = 2'b01; w_rw = w_cond_ex;
      end
      S_MEMWR: begin
        adr_src = 1'b1; w_mw = w_cond_ex & w_ready;
        w_next = w_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECR: begin
        alu_src_b = 2'b00; alu_control = w_alu_op; w_next = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_b = 2'b01; alu_control = w_alu_op; w_next = S_ALUWB;
      end
      S_ALUWB: begin
        w_rw  = w_cond_ex & ~w_no_write;
        w_pcw = w_cond_ex & (rd == 4'd15);
      end
      S_BRANCH: begin
        alu_src_b = 2'b01; result_src = 2'b10; w_pcw = w_cond_ex;
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign pc_write  = w_pcw & ~reset;
  assign mem_write = w_mw  & ~reset;
  assign ir_write  = w_irw & ~reset;
  assign reg_write = w_rw  & ~reset;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus random instructions
// compared cycle by cycle against a per-instruction expected-control-sequence model.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd, cond, alu_flag;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a;
  logic [1:0] result_src, alu_src_b, alu_control, imm_src, reg_src;
  logic [3:0] flags;
`ifdef MCTRL_WAIT_EN
  logic       mem_ready = 1'b1;
`endif

  int checks   = 0;
  int failures = 0;
  logic [3:0] m_flags;

  typedef struct packed {
    logic pcw, adr, mw, irw, rw;
    logic [1:0] rs;
    logic sa;
    logic [1:0] sb, ac;
  } ctl_t;

  ctl_t obs;
  assign obs = {pc_write, adr_src, mem_write, ir_write, reg_write,
                result_src, alu_src_a, alu_src_b, alu_control};

  multicycle_ctrl dut (
    .clk(clk), .reset(reset),
`ifdef MCTRL_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .op(op), .funct(funct), .rd(rd), .cond(cond), .alu_flag(alu_flag),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .imm_src(imm_src), .reg_src(reg_src), .flags(flags)
  );

  always #5 clk = ~clk;

  function automatic ctl_t mk(input logic pcw, adr, mw, irw, rw,
                              input logic [1:0] rs, input logic sa,
                              input logic [1:0] sb, ac);
    return ctl_t'({pcw, adr, mw, irw, rw, rs, sa, sb, ac});
  endfunction

  // Conditions come in complementary pairs: even code tests a predicate, odd code its inverse.
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] fl);
    logic n, z, cf, v, base;
    {n, z, cf, v} = fl;
    if (c == 4'hF) return 1'b0;
    if (c == 4'hE) return 1'b1;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return base ^ c[0];
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 of the next FETCH.
  task automatic run_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                           input logic [3:0] c, input logic [3:0] af, input string tag);
    ctl_t q[$];
    logic [3:0] fq[$];
    logic ce, ce2, nw;
    logic [1:0] ac;
    logic [3:0] nf;
    op = o; funct = f; rd = r; cond = c; alu_flag = af;
    ce = cond_ok(c, m_flags);
    nw = 1'b0;
    case (f[4:1])
      4'd4:  ac = 2'd0;
      4'd2:  ac = 2'd1;
      4'd0:  ac = 2'd2;
      4'd12: ac = 2'd3;
      4'd10: begin ac = 2'd1; nw = 1'b1; end
      default: begin ac = 2'd0; nw = 1'b1; end
    endcase
    nf = m_flags;
    q.push_back(mk(1, 0, 0, 1, 0, 2'd2, 1, 2'd2, 2'd0));
    q.push_back(mk(0, 0, 0, 0, 0, 2'd2, 1, 2'd2, 2'd0));
    case (o)
      2'b01: begin
        q.push_back(mk(0, 0, 0, 0, 0, 2'd0, 0, 2'd1, 2'd0));
        if (f[0]) begin
          q.push_back(mk(0, 1, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0));
          q.push_back(mk(0, 0, 0, 0, ce, 2'd1, 0, 2'd0, 2'd0));
        end else
          q.push_back(mk(0, 1, ce, 0, 0, 2'd0, 0, 2'd0, 2'd0));
      end
      2'b00: begin
        q.push_back(mk(0, 0, 0, 0, 0, 2'd0, 0, f[5] ? 2'd1 : 2'd0, ac));
        if (f[0] && ce) nf = {af[3:2], ac[1] ? m_flags[1:0] : af[1:0]};
        ce2 = cond_ok(c, nf);
        q.push_back(mk(ce2 && r == 4'd15, 0, 0, 0, ce2 && !nw, 2'd0, 0, 2'd0, 2'd0));
      end
      2'b10: q.push_back(mk(ce, 0, 0, 0, 0, 2'd2, 0, 2'd1, 2'd0));
      default: ;
    endcase
    for (int i = 0; i < q.size(); i++) fq.push_back((o == 2'b00 && i == 3) ? nf : m_flags);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      chk($sformatf("%s.ctl%0d", tag, i), 16'(obs), 16'(q[i]));
      chk($sformatf("%s.flags%0d", tag, i), 16'(flags), 16'(fq[i]));
      chk($sformatf("%s.src%0d", tag, i), 16'({imm_src, reg_src}),
          16'({o, o == 2'b01, o == 2'b10}));
      @(posedge clk); #1;
    end
    m_flags = nf;
  endtask

  initial begin
    reset = 1'b1; op = 2'b11; funct = '0; rd = '0; cond = 4'hE; alu_flag = '0;
    m_flags = '0;
    #2;
    chk("rst.flags", 16'(flags), 16'h0);
    chk("rst.ctl", 16'(obs), 16'(mk(0, 0, 0, 0, 0, 2'd2, 1, 2'd2, 2'd0)));
    #5 reset = 1'b0;

    run_instr(2'b00, 6'b001000, 4'd3, 4'hE, 4'h0, "add_reg");
    run_instr(2'b00, 6'b110101, 4'd1, 4'hE, 4'b0100, "cmp_imm");
    chk("cmp.flags", 16'(flags), 16'b0100);
    run_instr(2'b10, 6'b000000, 4'd0, 4'b0001, 4'h0, "bne");
    run_instr(2'b01, 6'b000001, 4'd2, 4'hE, 4'h0, "ldr");
    run_instr(2'b00, 6'b110101, 4'd1, 4'hE, 4'b0000, "cmp_z0");
    run_instr(2'b01, 6'b000000, 4'd2, 4'b0000, 4'h0, "str_eq");
    run_instr(2'b00, 6'b001000, 4'd15, 4'hE, 4'h0, "add_pc");
    run_instr(2'b11, 6'b000000, 4'd0, 4'hE, 4'h0, "undef");

    // Reset arriving mid-MEMRD must clear flags and return to FETCH without a clock edge.
    run_instr(2'b00, 6'b110101, 4'd1, 4'hE, 4'b1111, "cmp_f");
    op = 2'b01; funct = 6'b000001; cond = 4'hE;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("memrd.ctl", 16'(obs), 16'(mk(0, 1, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0)));
    #1 reset = 1'b1;
    #1;
    chk("async.flags", 16'(flags), 16'h0);
    chk("async.ctl", 16'(obs), 16'(mk(0, 0, 0, 0, 0, 2'd2, 1, 2'd2, 2'd0)));
    @(posedge clk); #2 reset = 1'b0;
    m_flags = '0;
    run_instr(2'b00, 6'b011000, 4'd5, 4'hE, 4'h0, "post_rst");

`ifdef MCTRL_WAIT_EN
    op = 2'b11; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("wait.hold%0d", i), 16'(obs), 16'(mk(0, 0, 0, 0, 0, 2'd2, 1, 2'd2, 2'd0)));
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("wait.go", 16'(obs), 16'(mk(1, 0, 0, 1, 0, 2'd2, 1, 2'd2, 2'd0)));
    @(posedge clk); #1;
    @(negedge clk);
    chk("wait.dec", 16'(obs), 16'(mk(0, 0, 0, 0, 0, 2'd2, 1, 2'd2, 2'd0)));
    @(posedge clk); #1;
`endif

    for (int n = 0; n < 150; n++)
      run_instr(2'($urandom), 6'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                $sformatf("rnd%0d", n));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
